dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the data cache's miss/refill interface. It accepts one request at a time from the cache controller, either a line refill read or a single-word write-through. After a programmable access latency it streams back a line of words, or returns a write acknowledge. It replaces the ideal single-cycle data memory behind `d_cache` in the pipelined RISC-V core and provides realistic miss penalties for hazard and stall testing.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: log2 of the array depth in 32-bit words.
- `LINE_WORDS`, 4: words per cache line; must be a power of two, at least 2.
- `LATENCY`, 3: access wait cycles before the first response; must be at least 1.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `req_valid`  in  1  Cache presents a request.
- `req_ready`  out  1  Responder can accept a request; high only in IDLE.
- `req_we`  in  1  1 = single-word write, 0 = line refill read.
- `req_addr`  in  32  Word address; the memory is word-addressed.
- `req_wdata`  in  32  Write data.
- `rsp_valid`  out  1  Response beat valid. There is no backpressure: the cache must take every beat.
- `rsp_data`  out  32  Read data, or echoed write data on a write ack.
- `rsp_idx`  out  log2(LINE_WORDS)  Word index within the line for this beat.
- `rsp_last`  out  1  Final beat of a read burst, or the write ack.
- `busy`  out  1  High in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, BURST, WACK.
- **IDLE:** `req_ready`=1. On `req_valid`&&`req_ready`, the responder latches `req_we`, `req_addr` and `req_wdata`, loads the wait counter with `LATENCY`-1, and moves to WAIT.
- **WAIT:** the counter decrements once per cycle. When it reaches 0:
  - Read: issue the array read for the first beat's index and go to BURST.
  - Write: write `req_wdata` into the array and go to WACK.
- **BURST:** one beat per cycle for `LINE_WORDS` cycles.
  - Each beat drives `rsp_valid`=1, `rsp_data` = array[line_base + idx] and `rsp_idx` = idx.
  - The next index is prefetched from the array in the same cycle.
  - `rsp_last`=1 on the final beat, which returns to IDLE.
- **WACK:** a one-cycle pulse: `rsp_valid`=1, `rsp_last`=1, `rsp_data` = written data, `rsp_idx` = addr low bits. Returns to IDLE.
- **Address arithmetic:**
  - Array index = `req_addr[DEPTH_LOG2-1:0]`; higher bits are ignored, so addresses wrap (alias).
  - line_base = index with the low log2(`LINE_WORDS`) bits cleared.
  - Burst index arithmetic is modulo `LINE_WORDS`.
- While not in IDLE, `req_valid` is ignored; the request is not consumed.
- Array contents are never reset; they hold their values across `rst`.
- **Reset:** `rst` low forces IDLE immediately.
  - `req_ready`=1; `rsp_valid`, `rsp_last`, `busy`=0; `rsp_data`, `rsp_idx`=0.
  - An in-flight write whose array write has not yet occurred is dropped.

## Timing
- Request accepted at edge E0.
- Read: WAIT occupies cycles 1..`LATENCY`. Beats occur in cycles `LATENCY`+1 .. `LATENCY`+`LINE_WORDS`. `req_ready`=1 again in cycle `LATENCY`+`LINE_WORDS`+1.
- Write: the array is updated at the edge ending cycle `LATENCY`. The ack is in cycle `LATENCY`+1, and IDLE follows in cycle `LATENCY`+2.
- Minimum request spacing:
  - Read: `LATENCY`+`LINE_WORDS`+1 cycles.
  - Write: `LATENCY`+2 cycles.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- `DMEM_CRIT_WORD_FIRST_EN` defined: the burst starts at the requested word index `req_addr[log2(LINE_WORDS)-1:0]` and wraps modulo `LINE_WORDS`. Example: index 2 with 4-word lines gives beats 2,3,0,1.
- Undefined: the burst always starts at index 0 and runs in order 0..`LINE_WORDS`-1.
- `rsp_idx` always reports the true index, so the cache fills correctly in either mode.

## Structure
- Package `dmem_pkg`: state enum (IDLE, WAIT, BURST, WACK), default `LINE_WORDS`/`LATENCY` constants, and the index width function/localparam.
- Sub-module `dmem_array`: single-port synchronous RAM, one read or one write per cycle, 1-cycle read latency, no reset.
- `dmem_responder` holds the FSM, wait counter, beat counter and address/data registers.

## Test plan
All scenarios use default parameters unless stated.
1. Reset: hold `rst` low 3 cycles, release -> `req_ready`=1, `rsp_valid`=0, `busy`=0. Pulse `rst` low mid-WAIT -> outputs return to these values within the same cycle.
2. Write 0x0000_0012 / 0xDEADBEEF accepted at cycle 0 -> single ack at cycle 4: `rsp_valid`=1, `rsp_last`=1, `rsp_idx`=2, `rsp_data`=0xDEADBEEF. `req_ready`=1 at cycle 5.
3. After preloading words 0x10..0x13 with 0xA0..0xA3, read 0x12 at cycle 0 -> beats at cycles 4..7.
   - Macro off: idx 0,1,2,3, data 0xA0..0xA3.
   - Macro on: idx 2,3,0,1, data 0xA2,0xA3,0xA0,0xA1.
   - `rsp_last` only at cycle 7.
4. `req_valid` held high continuously with a second read queued -> second request accepted only at cycle 8; its first beat appears at cycle 12.
5. Aliasing: write 0x0000_0412 with `DEPTH_LOG2`=10, then read 0x12 -> beat idx 2 returns the written value.
6. `rst` low during beat 2 of a burst -> `rsp_valid` drops immediately with no further beats. A subsequent read returns the same data as before the reset (array retained).

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, default parameters and index width helper for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int DEFAULT_LATENCY    = 3;

    function automatic int idx_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM, 1-cycle read latency, contents never reset
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-programmable line-refill / write-through memory responder
// Optional feature: DMEM_CRIT_WORD_FIRST_EN starts each burst at the requested word and wraps.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [31:0]                       req_addr,
    input  logic [31:0]                       req_wdata,
    output logic                              rsp_valid,
    output logic [31:0]                       rsp_data,
    output logic [idx_width(LINE_WORDS)-1:0]  rsp_idx,
    output logic                              rsp_last,
    output logic                              busy
);

    localparam int IDX_W = idx_width(LINE_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        wait_cnt;
    logic [IDX_W-1:0]        beat_cnt;
    logic [IDX_W-1:0]        cur_idx;
    logic [IDX_W-1:0]        start_idx;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    mem_en;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [31:0]             mem_rdata;
    logic                    unused_addr_hi;

    // Upper address bits alias onto the array.
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2];

`ifdef DMEM_CRIT_WORD_FIRST_EN
    assign start_idx = addr_q[IDX_W-1:0];
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
            cur_idx  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr[DEPTH_LOG2-1:0];
                        wdata_q  <= req_wdata;
                        wait_cnt <= CNT_W'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                    beat_cnt <= '0;
                    cur_idx  <= start_idx;
                end
                BURST: begin
                    beat_cnt <= beat_cnt + IDX_W'(1);
                    cur_idx  <= cur_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The array read for beat n+1 is issued during beat n so data is ready on the next edge.
    always_comb begin
        state_n  = state;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr_q;
        case (state)
            IDLE: begin
                if (req_valid) state_n = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    mem_en = 1'b1;
                    if (we_q) begin
                        mem_we  = 1'b1;
                        state_n = WACK;
                    end else begin
                        mem_addr = {addr_q[DEPTH_LOG2-1:IDX_W], start_idx};
                        state_n  = BURST;
                    end
                end
            end
            BURST: begin
                mem_en   = 1'b1;
                mem_addr = {addr_q[DEPTH_LOG2-1:IDX_W], IDX_W'(cur_idx + IDX_W'(1))};
                if (beat_cnt == LAST_BEAT) state_n = IDLE;
            end
            WACK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_data  = '0;
        rsp_idx   = '0;
        case (state)
            BURST: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_cnt == LAST_BEAT);
                rsp_data  = mem_rdata;
                rsp_idx   = cur_idx;
            end
            WACK: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                rsp_data  = wdata_q;
                rsp_idx   = addr_q[IDX_W-1:0];
            end
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int LW         = 4;
    localparam int LAT        = 3;
    localparam int IW         = 2;

`ifdef DMEM_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [IW-1:0] rsp_idx;
    logic          rsp_last;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [1 << DEPTH_LOG2];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LINE_WORDS (LW),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_idx   (rsp_idx),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".ctl"}, 32'({req_ready, busy, rsp_valid, rsp_last}), 32'(4'b1000));
        check_eq({tag, ".data"}, rsp_data, 32'h0);
        check_eq({tag, ".idx"}, 32'(rsp_idx), 32'h0);
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle 1.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        check_eq("accept_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic finish(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int base;
        int start;
        int idx;
        for (int k = 1; k <= LAT; k++) begin
            check_eq("wait_state", 32'({busy, req_ready, rsp_valid}), 32'(3'b100));
            @(negedge clk);
        end
        if (we) begin
            check_eq("wack_ctl", 32'({rsp_valid, rsp_last}), 32'(2'b11));
            check_eq("wack_idx", 32'(rsp_idx), addr % LW);
            check_eq("wack_data", rsp_data, wdata);
            mem_model[addr[DEPTH_LOG2-1:0]] = wdata;
            @(negedge clk);
        end else begin
            base  = int'(addr[DEPTH_LOG2-1:0]) & ~(LW - 1);
            start = CWF ? int'(addr % LW) : 0;
            for (int b = 0; b < LW; b++) begin
                idx = (start + b) % LW;
                check_eq("beat_ctl", 32'({rsp_valid, rsp_last, busy}), 32'({1'b1, b == LW - 1, 1'b1}));
                check_eq("beat_idx", 32'(rsp_idx), idx);
                check_eq("beat_data", rsp_data, mem_model[base + idx]);
                @(negedge clk);
            end
        end
        check_eq("back_idle", 32'({req_ready, busy, rsp_valid}), 32'(3'b100));
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        issue(we, addr, wdata, hold);
        finish(we, addr, wdata);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;

        repeat (3) @(negedge clk);
        check_eq("in_reset_ready", 32'(req_ready), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset");

        xact(1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 1'b0);

        for (int i = 0; i < 64; i++) xact(1'b1, 32'(i), $urandom, 1'b0);
        for (int i = 0; i < 4; i++) xact(1'b1, 32'(16 + i), 32'hA0 + 32'(i), 1'b0);
        xact(1'b0, 32'h0000_0012, 32'h0, 1'b0);

        // Request held high across a burst must not be consumed early.
        xact(1'b0, 32'h0000_0012, 32'h0, 1'b1);
        xact(1'b0, 32'h0000_0011, 32'h0, 1'b0);

        xact(1'b1, 32'h0000_0412, 32'hCAFE_F00D, 1'b0);
        xact(1'b0, 32'h0000_0012, 32'h0, 1'b0);

        issue(1'b1, 32'h0000_0005, 32'h1234_5678, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_wait_rel");
        xact(1'b0, 32'h0000_0004, 32'h0, 1'b0);

        issue(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        repeat (LAT) @(negedge clk);
        check_eq("pre_rst_beat", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_burst");
        @(negedge clk);
        check_eq("rst_burst_hold", 32'({rsp_valid, busy}), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_burst_rel");
        xact(1'b0, 32'h0000_0010, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            we    = 1'($urandom % 2);
            addr  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            wdata = $urandom;
            hold  = bit'($urandom % 2);
            xact(we, addr, wdata, hold);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("final_idle", 32'({req_ready, busy, rsp_valid}), 32'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
